// File: rtl/regfile_pkg.sv
// Shared register-file read-port constants and types.
// MUX32_TO_1_PIPE_EN selects the two-cycle read latency.
package regfile_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned SEL_W     = 5;

    typedef logic [SEL_W-1:0] mux_sel_t;

`ifdef MUX32_TO_1_PIPE_EN
    localparam int unsigned MUX_LATENCY = 2;
`else
    localparam int unsigned MUX_LATENCY = 1;
`endif

endpackage

// File: rtl/mux2_1.sv
// Combinational 2-to-1 bit selector; the leaf cell of the read-port select tree.
module mux2_1 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic out
);

    assign out = sel ? i1 : i0;

endmodule

// File: rtl/mux32_to_1.sv
// Single-bit 32-to-1 selector built from 2-to-1 stages, registered output.
// Defining MUX32_TO_1_PIPE_EN adds a pipeline register after stage 2 (latency 2).
module mux32_to_1
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_COUNT-1:0] in,
    input  mux_sel_t             sel,
    output logic                 out
);

    logic [15:0] st0;
    logic [7:0]  st1;
    logic [3:0]  st2;
    logic [3:0]  st3_in;
    logic [1:0]  sel_hi;
    logic [1:0]  st3;
    logic        st4;
    logic        out_d;
    logic        out_q;

    for (genvar m = 0; m < 16; m++) begin : g_st0
        mux2_1 u_mux (.i0(in[2*m]), .i1(in[2*m+1]), .sel(sel[0]), .out(st0[m]));
    end

    for (genvar m = 0; m < 8; m++) begin : g_st1
        mux2_1 u_mux (.i0(st0[2*m]), .i1(st0[2*m+1]), .sel(sel[1]), .out(st1[m]));
    end

    for (genvar m = 0; m < 4; m++) begin : g_st2
        mux2_1 u_mux (.i0(st1[2*m]), .i1(st1[2*m+1]), .sel(sel[2]), .out(st2[m]));
    end

`ifdef MUX32_TO_1_PIPE_EN
    logic [3:0] st2_q;
    logic [1:0] sel_hi_q;

    // Upper select bits travel with the partial results so both halves stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            st2_q    <= '0;
            sel_hi_q <= '0;
        end else begin
            st2_q    <= st2;
            sel_hi_q <= sel[4:3];
        end
    end

    assign st3_in = st2_q;
    assign sel_hi = sel_hi_q;
`else
    assign st3_in = st2;
    assign sel_hi = sel[4:3];
`endif

    for (genvar m = 0; m < 2; m++) begin : g_st3
        mux2_1 u_mux (.i0(st3_in[2*m]), .i1(st3_in[2*m+1]), .sel(sel_hi[0]), .out(st3[m]));
    end

    mux2_1 u_st4 (.i0(st3[0]), .i1(st3[1]), .sel(sel_hi[1]), .out(st4));

    assign out_d = st4;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mux32_to_1.sv
// Directed bench for mux32_to_1: vector table plus reset and streaming sequences.
module tb_mux32_to_1;
    import regfile_pkg::*;

    typedef struct {
        logic [31:0] in_v;
        logic [4:0]  sel_v;
        logic        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_v;
    logic [4:0]  sel_v;
    logic        out;

    int checks   = 0;
    int failures = 0;

    logic [MUX_LATENCY-1:0] exp_pipe;
    vec_t vecs[$];

    mux32_to_1 dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_v),
        .sel   (sel_v),
        .out   (out)
    );

    always #5 clk = ~clk;

    // Advance one edge; the delay-line model tracks what the output should show.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            exp_pipe = '0;
        end else begin
            for (int i = MUX_LATENCY - 1; i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
            exp_pipe[0] = in_v[sel_v];
        end
        #1;
    endtask

    task automatic check(input string name, input logic req);
        checks++;
        if (out !== req) begin
            failures++;
            $display("FAIL %s: out=%b required=%b (in=%h sel=%0d)", name, out, req, in_v, sel_v);
        end
    endtask

    initial begin
        exp_pipe = '0;

        // Reset held two cycles with all-ones input.
        reset = 1'b1;
        in_v  = 32'hFFFF_FFFF;
        sel_v = 5'd7;
        step();
        check("reset_c0", 1'b0);
        step();
        check("reset_c1", 1'b0);
        reset = 1'b0;
        for (int i = 0; i < MUX_LATENCY; i++) begin
            step();
            check("reset_release", exp_pipe[MUX_LATENCY-1]);
        end
        check("reset_release_final", 1'b1);

        // Vector table.
        for (int k = 0; k < 32; k++) vecs.push_back('{32'h1 << k, 5'(k), 1'b1});
        for (int k = 0; k < 32; k++) vecs.push_back('{~(32'h1 << k), 5'(k), 1'b0});
        for (int k = 0; k < 32; k++) vecs.push_back('{~(32'h1 << k), 5'((k + 1) % 32), 1'b1});
        vecs.push_back('{32'h8000_0000, 5'd31, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 5'd31, 1'b0});
        vecs.push_back('{32'h0000_0001, 5'd31, 1'b0});
        vecs.push_back('{32'h0000_0000, 5'd0,  1'b0});
        vecs.push_back('{32'h0001_0000, 5'd16, 1'b1});
        vecs.push_back('{32'hFFFE_FFFF, 5'd16, 1'b0});

        foreach (vecs[i]) begin
            in_v  = vecs[i].in_v;
            sel_v = vecs[i].sel_v;
            for (int c = 0; c < MUX_LATENCY; c++) step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-to-back sweep over AAAA_AAAA: odd indices select 1.
        in_v = 32'hAAAA_AAAA;
        for (int s = 0; s < 32; s++) begin
            sel_v = 5'(s);
            step();
            check($sformatf("b2b_sel%0d", s), exp_pipe[MUX_LATENCY-1]);
        end
        // Same sweep with a one-cycle reset at sel=10.
        for (int s = 0; s < 32; s++) begin
            sel_v = 5'(s);
            reset = (s == 10);
            step();
            if (s == 10) check("midreset_zero", 1'b0);
            else check($sformatf("midreset_sel%0d", s), exp_pipe[MUX_LATENCY-1]);
        end
        reset = 1'b0;
        for (int i = 0; i < MUX_LATENCY; i++) begin
            sel_v = 5'd13;
            step();
        end
        check("midreset_resume", 1'b1);

        // in and sel change together every cycle.
        for (int i = 0; i < 24; i++) begin
            in_v  = $urandom;
            sel_v = 5'($urandom_range(31, 0));
            step();
            check($sformatf("joint%0d", i), exp_pipe[MUX_LATENCY-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
